// File: rtl/queue_4x8.sv
// Purpose: synchronous FIFO, WIDTH bits x DEPTH entries, first-word-fall-through head, sticky error flags.
// Latency: a write into an empty queue is visible on data_out right after its edge; all outputs come from registers.
// Backpressure: a write to a full queue is refused unless paired with an accepted read; a refused write sets overflow and a read of an empty queue sets underflow.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   wr_en, data_in      write request and its data, sampled on the rising edge
//   rd_en               pop the entry currently shown on data_out
//   data_out            head entry, forced to 0 while empty
//   full, empty, count  occupancy decoded from the registered count
//   overflow, underflow sticky error flags, cleared only by reset
module queue_4x8 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;

  // A full queue still takes a write when the same edge frees a slot.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Stale entries stay in memory after a pop or reset; the mask keeps them hidden.
  assign data_out = empty ? '0 : mem[rp];

  // Storage is not reset; the reset gate only discards writes issued on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers roll over naturally at DEPTH since DEPTH is a power of two.
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
      else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
      if (wr_en && !wr_ok) overflow  <= 1'b1;
      if (rd_en && !rd_ok) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_queue_4x8.sv
module tb_queue_4x8;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] data_in;
  logic       rd_en;
  logic [3:0] data_out;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  queue_4x8 dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue of stored values plus sticky flags.
  int model_q[$];
  bit m_ovf;
  bit m_udf;
  // Scoreboard: values the consumer must see, in order.
  int exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: whenever the consumer pops a presented head, compare it with the scoreboard.
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0d, required no pop at %0t", data_out, $time);
      end else begin
        chk("pop_data", int'(data_out), exp_q.pop_front());
      end
    end
  end

  task automatic check_state(string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"},     int'(count),     sz);
    chk({tag, ".empty"},     int'(empty),     (sz == 0) ? 1 : 0);
    chk({tag, ".full"},      int'(full),      (sz == DEPTH) ? 1 : 0);
    chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(m_udf));
    chk({tag, ".data_out"},  int'(data_out),  (sz == 0) ? 0 : model_q[0]);
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic cyc(bit w, bit r, int d, string tag);
    bit rok;
    bit wok;
    wr_en   = w;
    rd_en   = r;
    data_in = 4'(d);
    rok = r && (model_q.size() != 0);
    wok = w && ((model_q.size() < DEPTH) || rok);
    if (rok) exp_q.push_back(model_q[0]);
    @(posedge clk);
    if (rok) void'(model_q.pop_front());
    if (wok) model_q.push_back(d & 15);
    if (w && !wok) m_ovf = 1'b1;
    if (r && !rok) m_udf = 1'b1;
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(int n, bit w, bit r, int d);
    reset   = 1'b1;
    wr_en   = w;
    rd_en   = r;
    data_in = 4'(d);
    repeat (n) @(posedge clk);
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state("reset");
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= 8; i++) cyc(1, 0, i, "fill");
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, "drain");
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    @(posedge clk);
    #1;

    // Reset while requesting both ends.
    do_reset(2, 1, 1, 15);
    chk("reset_empty", int'(empty), 1);
    chk("reset_data", int'(data_out), 0);

    // Fill and drain.
    fill_1_to_8();
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    drain(8);
    chk("drain_empty", int'(empty), 1);
    chk("drain_no_ovf", int'(overflow), 0);

    // Overflow: the refused 0xA must never appear.
    fill_1_to_8();
    cyc(1, 0, 10, "ovf");
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 8);
    drain(8);

    // Underflow then simultaneous on empty.
    do_reset(1, 0, 0, 0);
    cyc(0, 1, 0, "udf");
    chk("udf_flag", int'(underflow), 1);
    chk("udf_count", int'(count), 0);
    cyc(1, 1, 5, "empty_rw");
    chk("empty_rw_count", int'(count), 1);
    chk("empty_rw_data", int'(data_out), 5);
    drain(1);

    // Full simultaneous with pointer wrap.
    do_reset(1, 0, 0, 0);
    fill_1_to_8();
    for (int i = 9; i <= 12; i++) cyc(1, 1, i, "full_rw");
    chk("full_rw_full", int'(full), 1);
    chk("full_rw_no_ovf", int'(overflow), 0);
    drain(8);

    // Reset mid-operation.
    cyc(1, 0, 3, "mid");
    cyc(1, 0, 4, "mid");
    cyc(1, 0, 5, "mid");
    do_reset(1, 0, 0, 0);
    cyc(1, 0, 6, "mid_wr");
    chk("mid_data", int'(data_out), 6);
    chk("mid_count", int'(count), 1);
    cyc(0, 1, 0, "mid_rd");
    chk("mid_empty", int'(empty), 1);

    // Randomized traffic in write-heavy, balanced and read-heavy phases.
    for (int ph = 0; ph < 3; ph++) begin
      int wp_pct;
      int rp_pct;
      wp_pct = (ph == 0) ? 80 : (ph == 1) ? 50 : 25;
      rp_pct = (ph == 0) ? 25 : (ph == 1) ? 50 : 80;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
        end else begin
          cyc($urandom_range(0, 99) < wp_pct, $urandom_range(0, 99) < rp_pct,
              int'($urandom_range(0, 15)), "rand");
        end
      end
    end

    drain(DEPTH + 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/queue_4x8.md
# queue_4x8

Synchronous first-in/first-out buffer, 4 bits wide and 8 entries deep. It is the queue counterpart of the team's 4x8 LIFO stack and sits between a producer and a consumer that run on the same clock. It has independent write and read ends, first-word-fall-through output, occupancy count, and sticky overflow/underflow error flags.

## Interface
Parameters:
- WIDTH, 4, data width in bits
- DEPTH, 8, number of entries; must be a power of two, at least 2
- Derived: AW = log2(DEPTH), 3 at defaults

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request; data_in sampled on the same edge
- data_in  input  WIDTH  write data
- rd_en  input  1  read request; pops the entry currently shown on data_out
- data_out  output  WIDTH  oldest entry (head); 0 when empty
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  AW+1  number of stored entries, 0..DEPTH
- overflow  output  1  sticky: set by a rejected write
- underflow  output  1  sticky: set by a rejected read

## Operation
- Storage: DEPTH x WIDTH register array, plus write pointer wp and read pointer rp (AW bits each) and count (AW+1 bits).
- Pointers wrap modulo DEPTH with natural AW-bit rollover; no special-case logic is used.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && (!full || rd_ok). A write to a full queue is accepted only when it is paired with an accepted read.
- On wr_ok: mem[wp] <= data_in, and wp increments.
- On rd_ok: rp increments. The memory entry itself is not cleared.
- count update:
  - wr_ok only: count + 1
  - rd_ok only: count - 1
  - both or neither: count unchanged
- full and empty are decoded combinationally from the registered count.
- data_out = empty ? 0 : mem[rp]. It is combinational from registered state.
- Rejected write (wr_en && !wr_ok): memory, wp and count are unchanged, and overflow <= 1.
- Rejected read (rd_en && empty): rp and count are unchanged, and underflow <= 1.
- overflow and underflow hold until reset. No other input clears them.
- Simultaneous read and write:
  - On a full queue: both are accepted, the head is replaced by the next entry, count stays DEPTH, and overflow is not set.
  - On an empty queue: the write is accepted and the read is rejected. underflow is set and count becomes 1.
  - At any other occupancy: both are accepted and count is unchanged.

## Timing
- Reset, on an edge with reset=1: wp=0, rp=0, count=0, overflow=0, underflow=0. Consequently empty=1, full=0 and data_out=0 from that edge onward.
- Reset has priority over wr_en and rd_en on the same edge; any request on that edge is discarded.
- Memory contents are not reset. data_out is masked to 0 while empty, so stale contents are never visible.
- Write-to-read latency:
  - Data written at edge N appears on data_out immediately after edge N if the queue was empty.
  - empty deasserts after edge N.
- Read: after the edge on which rd_ok is true, data_out shows the next entry, or 0 if the queue became empty.
- full asserts after the edge of the DEPTH-th net write and deasserts after the first net read.
- No combinational path from inputs to outputs. All outputs depend only on registered state.
- Reset mid-operation: the queue is empty on the next cycle regardless of prior contents. Pointers restart at 0.

## Test plan
- Reset check: assert reset for 2 cycles with wr_en=rd_en=1 and data_in=0xF. Required: empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
- Fill and drain:
  - Stimulus: write 0x1..0x8 on consecutive cycles, then read 8 cycles.
  - Required during fill: full=1 and count=8 after the 8th write.
  - Required during drain: data_out sequence 0x1,0x2,...,0x8, then empty=1 and data_out=0. No error flags.
- Overflow: fill with 0x1..0x8, then write 0xA once.
  - Required: overflow=1 and count=8.
  - Subsequent drain still yields 0x1..0x8; 0xA never appears.
- Underflow and empty-simultaneous:
  - Stimulus: on an empty queue, rd_en=1 alone.
  - Required: underflow=1, count=0.
  - Stimulus: then wr_en=rd_en=1 with data_in=0x5.
  - Required: count=1, data_out=0x5.
- Full-simultaneous with wrap:
  - Stimulus: fill with 0x1..0x8, then 4 cycles of wr_en=rd_en=1 with data 0x9..0xC.
  - Required: count stays 8, full stays 1, no overflow.
  - Required on drain: 0x5,0x6,0x7,0x8,0x9,0xA,0xB,0xC.
- Reset mid-operation:
  - Stimulus: write 0x3,0x4,0x5, pulse reset one cycle, then write 0x6 and read once.
  - Required: data_out=0x6 before the read, count=1 before the read, then empty=1.
